// File: rtl/ex_alu_pkg.sv
// Shared Execute-stage ALU definitions: serial add/sub FSM encodings and
// saturation limits for the default datapath width.
package ex_alu_pkg;

  localparam logic [1:0] SA_IDLE = 2'b00;
  localparam logic [1:0] SA_RUN  = 2'b01;
  localparam logic [1:0] SA_DONE = 2'b10;

  localparam int unsigned SA_WIDTH = 16;

  localparam logic [SA_WIDTH-1:0] SAT_MAX = {1'b0, {(SA_WIDTH-1){1'b1}}};
  localparam logic [SA_WIDTH-1:0] SAT_MIN = {1'b1, {(SA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used by the bit-serial add/subtract sequencer.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);

  assign sum_c  = a ^ b ^ cin;
  assign cout_c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full_adder cell, LSB first, one bit per cycle,
// producing an optionally saturated result with Z/V/N/C flags.
module serial_addsub
  import ex_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = SA_WIDTH,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SAT_MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovfl_q, ovfl_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic             fa_sum_c, fa_cout_c;
  logic [WIDTH-1:0] raw_c;
  logic             ovfl_raw_c;
  logic [WIDTH-1:0] sat_sum_c;

  full_adder u_fa (
    .a      (opa_q[0]),
    .b      (opb_q[0]),
    .cin    (carry_q),
    .sum_c  (fa_sum_c),
    .cout_c (fa_cout_c)
  );

  // In the last RUN cycle carry_q is the carry into the MSB.
  assign raw_c      = {fa_sum_c, res_q};
  assign ovfl_raw_c = carry_q ^ fa_cout_c;
  assign sat_sum_c  = (SAT_EN && ovfl_raw_c) ?
                      (raw_c[WIDTH-1] ? SAT_MAX_W : SAT_MIN_W) : raw_c;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovfl_d  = ovfl_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    case (state_q)
      SA_IDLE, SA_DONE: begin
        if (start) begin
          state_d = SA_RUN;
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = SA_IDLE;
        end
      end
      SA_RUN: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        res_d   = raw_c[WIDTH-1:1];
        carry_d = fa_cout_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = SA_DONE;
          cout_d  = fa_cout_c;
          ovfl_d  = ovfl_raw_c;
          sum_d   = sat_sum_c;
          zero_d  = (sat_sum_c == '0);
          neg_d   = sat_sum_c[WIDTH-1];
        end
      end
      default: state_d = SA_IDLE;
    endcase

    busy_d = (state_d == SA_RUN);
    done_d = (state_d == SA_DONE) && (state_q == SA_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SA_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovfl = ovfl_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: a saturating and a wrapping instance share stimulus and
// are checked every cycle against an arithmetic reference plus literal results.
module tb_serial_addsub;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sub_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;

  logic         busy [2];
  logic         done [2];
  logic [W-1:0] sum  [2];
  logic         cout [2];
  logic         ovfl [2];
  logic         zero [2];
  logic         neg  [2];

  int tests = 0;
  int fails = 0;

  serial_addsub #(.WIDTH(W), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .sub(sub_i),
    .busy(busy[0]), .done(done[0]), .sum(sum[0]), .cout(cout[0]),
    .ovfl(ovfl[0]), .zero(zero[0]), .neg(neg[0])
  );

  serial_addsub #(.WIDTH(W), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .sub(sub_i),
    .busy(busy[1]), .done(done[1]), .sum(sum[1]), .cout(cout[1]),
    .ovfl(ovfl[1]), .zero(zero[1]), .neg(neg[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input bit sat,
                                 output logic [W-1:0] s, output logic co, output logic ov);
    int sa, sb, sr;
    logic [W-1:0] raw;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    sr  = sub ? sa - sb : sa + sb;
    raw = sub ? a - b : a + b;
    co  = sub ? (a >= b) : ((32'(a) + 32'(b)) > 32'h0000_FFFF);
    ov  = (sr > 32767) || (sr < -32768);
    s   = (sat && ov) ? ((sr > 0) ? 16'h7FFF : 16'h8000) : raw;
  endfunction

  // Timing model: operation occupies 16 cycles after acceptance, then one done cycle.
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_sum  [2] = '{default: '0};
  logic         m_cout [2] = '{default: 1'b0};
  logic         m_ovfl [2] = '{default: 1'b0};
  logic [W-1:0] p_sum  [2] = '{default: '0};
  logic         p_cout [2] = '{default: 1'b0};
  logic         p_ovfl [2] = '{default: 1'b0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      for (int i = 0; i < 2; i++) begin
        m_sum[i] = '0; m_cout[i] = 1'b0; m_ovfl[i] = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          for (int i = 0; i < 2; i++) begin
            m_sum[i] = p_sum[i]; m_cout[i] = p_cout[i]; m_ovfl[i] = p_ovfl[i];
          end
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_left = W;
        for (int i = 0; i < 2; i++)
          ref_op(a_i, b_i, sub_i, (i == 0), p_sum[i], p_cout[i], p_ovfl[i]);
      end
    end
  end

  // Per-cycle comparison; zero/neg are 0 out of reset before any result exists.
  bit m_valid = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) m_valid <= 1'b0;
    else if (m_done) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cyc_busy%0d", i), 32'(busy[i]), 32'(m_busy));
      chk($sformatf("cyc_done%0d", i), 32'(done[i]), 32'(m_done));
      chk($sformatf("cyc_sum%0d", i),  32'(sum[i]),  32'(m_sum[i]));
      chk($sformatf("cyc_cout%0d", i), 32'(cout[i]), 32'(m_cout[i]));
      chk($sformatf("cyc_ovfl%0d", i), 32'(ovfl[i]), 32'(m_ovfl[i]));
      chk($sformatf("cyc_zero%0d", i), 32'(zero[i]),
          32'((m_done || m_valid) && (m_sum[i] == '0)));
      chk($sformatf("cyc_neg%0d", i),  32'(neg[i]),  32'(m_sum[i][W-1]));
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    a_i = a; b_i = b; sub_i = sub; start = 1'b1;
  endtask

  task automatic wait_done(input bit noise, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (noise && (n == 5 || n == 9)) begin
        start = 1'b1; a_i = ~a_i; b_i = b_i ^ 16'h00FF; sub_i = ~sub_i;
      end
      if (noise && (n == 6 || n == 10)) start = 1'b0;
      if (done[0] === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input bit noise);
    int lat;
    @(negedge clk);
    launch(a, b, sub);
    wait_done(noise, lat);
    chk({nm, "_latency"}, 32'(lat), 32'd17);
  endtask

  task automatic chk_res(input string nm, input int i, input logic [W-1:0] s,
                         input logic co, input logic ov, input logic z, input logic n);
    chk({nm, "_sum"},  32'(sum[i]),  32'(s));
    chk({nm, "_cout"}, 32'(cout[i]), 32'(co));
    chk({nm, "_ovfl"}, 32'(ovfl[i]), 32'(ov));
    chk({nm, "_zero"}, 32'(zero[i]), 32'(z));
    chk({nm, "_neg"},  32'(neg[i]),  32'(n));
  endtask

  initial begin
    int lat;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_done", 32'(done[0]), 32'd0);
    chk_res("reset", 0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Plain add
    run_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0);
    chk_res("t1_sat", 0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_res("t1_wrap", 1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

    // Positive overflow
    run_op("t2", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk_res("t2_sat", 0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_res("t2_wrap", 1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Negative overflow on subtract
    run_op("t3a", 16'h8000, 16'h0001, 1'b1, 1'b0);
    chk_res("t3a_sat", 0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_res("t3a_wrap", 1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    run_op("t3b", 16'h0005, 16'h0005, 1'b1, 1'b0);
    chk_res("t3b_sat", 0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Start and operand changes during RUN are ignored
    run_op("t4", 16'h1000, 16'h0234, 1'b0, 1'b1);
    chk_res("t4_sat", 0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t4_single_done", 32'(done[0]), 32'd0);
    end

    // Back-to-back: second start issued in the DONE cycle
    run_op("t6a", 16'h00FF, 16'h0100, 1'b1, 1'b0);
    chk_res("t6a_sat", 0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done(1'b0, lat);
    chk("t6b_latency", 32'(lat), 32'd17);
    chk_res("t6b_sat", 0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Async reset in the middle of RUN
    @(negedge clk);
    launch(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy[0]), 32'd0);
    chk_res("t5_rst_sat", 0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_res("t5_rst_wrap", 1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("t5_no_done", 32'(done[0]), 32'd0);
    end
    run_op("t5b", 16'h0F0F, 16'h0101, 1'b0, 1'b0);
    chk_res("t5b_sat", 0, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
